lab02_key_sender: RTL and testbench
===================================

# lab02_key_sender

Keypad-side driver for the lab02 combination lock. It replays a stored key code onto the lock's one-hot keypad lines X0..X3, one digit per slot, with an all-zero gap between digits. It then watches the lock's `lock` output to report whether the code opened the lock. It sits opposite `lab02_wave`: its X0..X3 connect to the lock's inputs, and the lock's `lock` output feeds back to it.

## Interface
- `CODE_LEN`, 4: number of digits replayed per attempt (≥1)
- `HOLD_CYC`, 1: cycles each key line is held high (≥1)
- `GAP_CYC`, 1: all-zero cycles after each digit (≥0; 0 means back-to-back keys)
- `CHK_CYC`, 4: cycles allowed for the lock to open after the last digit (≥1)

- `clk`  in  1  single clock; all state updates on rising edge
- `clean`  in  1  reset, synchronous, active-high
- `start`  in  1  begin an attempt; honoured only in IDLE
- `code`  in  2*CODE_LEN  digit i in `code[2i+1:2i]`, value 0..3 selects X0..X3; digit 0 is sent first
- `lock`  in  1  lock status from the lock; 1 = opened
- `X0`, `X1`, `X2`, `X3`  out  1 each  one-hot keypad lines, registered
- `busy`  out  1  high from the cycle after an accepted start until the cycle `done` is high
- `done`  out  1  one-cycle pulse at the end of an attempt
- `pass`  out  1  result of the last attempt; valid with `done`, held until the next accepted start

## Operation
- States:
  - IDLE: outputs low, waiting for `start`.
  - KEY: one-hot drive of the current digit.
  - GAP: all X low.
  - CHECK: sample `lock`.
  - DONE: one cycle.
- IDLE→KEY on `start`. At that edge `code` is captured into an internal register; later changes to `code` have no effect on the attempt.
- KEY lasts HOLD_CYC cycles, then goes to GAP, or straight to the next KEY if GAP_CYC=0.
- GAP lasts GAP_CYC cycles.
- After the last digit's KEY (and its GAP, if any), go to CHECK.
- Digit index counts 0..CODE_LEN-1 with no wrap within an attempt. It resets to 0 on each accepted start.
- CHECK: each cycle `lock`=1 → DONE with pass=1. If `lock` is not seen high within CHK_CYC cycles, go to DONE with pass=0.
- DONE: `done`=1 for one cycle, `busy`=0, then IDLE.
- `pass` clears to 0 on an accepted start.
- `start` while busy or in DONE is ignored, not queued.
- `lock` is ignored outside CHECK. The lock opening early, mid-code, does not set pass.
- At most one of X0..X3 is high in any cycle. All four are low outside KEY.
- Arithmetic: the digit counter is $clog2(CODE_LEN) bits, minimum 1. The cycle counter is sized for max(HOLD_CYC, GAP_CYC, CHK_CYC), counts down, and reloads on each state entry.

## Timing
- Reset (`clean`=1 at an edge) puts the block in IDLE at that edge:
  - X0..X3=0, busy=0, done=0, pass=0, counters 0.
  - Reset has priority over `start`.
  - Mid-attempt reset drops all key lines the next cycle.
- With `start` sampled at edge k:
  - busy=1 from k+1.
  - Digit 0's key line is high during cycles k+1..k+HOLD_CYC.
  - Digit d's key line rises at k+1+d*(HOLD_CYC+GAP_CYC).
- CHECK begins at k+1+CODE_LEN*(HOLD_CYC+GAP_CYC).
- `lock` sampled high in CHECK cycle j (0-based) gives done=1 in the next cycle.
- Worst-case latency from start to done is 1+CODE_LEN*(HOLD_CYC+GAP_CYC)+CHK_CYC cycles.
- A new `start` is accepted at the earliest in the first IDLE cycle after DONE.

## Structure
- `lab02_pkg` holds:
  - the state enum (IDLE, KEY, GAP, CHECK, DONE)
  - the 2-bit key index typedef
  - key constants KEY_X0..KEY_X3 = 0..3
- Sub-module `lab02_key_onehot`: 2-bit index plus enable → registered-ready 4-bit one-hot. It is reusable by the lock's bench. The top module contains the FSM, counters and code register.

## Test plan
- **Nominal code.** Defaults, code=8'hC2 (digits 2,0,0,3), start at edge k, lock tied 1 from k+9.
  - Required: X2@k+1, zero@k+2, X0@k+3, zero@k+4, X0@k+5, zero@k+6, X3@k+7, zero@k+8, done=1/pass=1@k+10.
- **Lock never opens.** Same code, lock=0 throughout.
  - Required: done@k+13, pass=0, busy low@k+13, X all 0 from k+8.
- **Back-to-back keys.** GAP_CYC=0, HOLD_CYC=2, code=8'h1B (digits 3,2,1,0).
  - Required: X3 k+1..k+2, X2 k+3..k+4, X1 k+5..k+6, X0 k+7..k+8, no zero cycle between them.
- **Ignored inputs during an attempt.** Pulse start and change code to 8'h00 during KEY of digit 1.
  - Required: the original sequence is unchanged and a single done is produced.
  - Also pulse lock=1 during KEY: pass is still 0 if lock=0 in CHECK.
- **Reset mid-operation.** Assert `clean` during digit 2.
  - Required: all X, busy, done, pass are 0 the next cycle.
  - A start two cycles later replays from digit 0.
  - `clean` and `start` asserted together leave the block in IDLE.

Source files
------------

// File: rtl/lab02_pkg.sv
// Shared types and constants for the lab02 combination-lock keypad driver.
package lab02_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_KEY   = 3'd1,
      ST_GAP   = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   typedef logic [1:0] key_idx_t;

   localparam key_idx_t KEY_X0 = 2'd0;
   localparam key_idx_t KEY_X1 = 2'd1;
   localparam key_idx_t KEY_X2 = 2'd2;
   localparam key_idx_t KEY_X3 = 2'd3;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lab02_key_onehot.sv
// Key index to one-hot keypad line decoder; output is meant to feed a register.
module lab02_key_onehot
   import lab02_pkg::*;
(
   input  logic [1:0] idx_i,
   input  logic       en_i,
   output logic [3:0] onehot_o
);

   // Decode the selected key line, all-zero when disabled.
   always_comb begin
      onehot_o = 4'b0000;
      if (en_i) begin
         case (key_idx_t'(idx_i))
            KEY_X0:  onehot_o = 4'b0001;
            KEY_X1:  onehot_o = 4'b0010;
            KEY_X2:  onehot_o = 4'b0100;
            KEY_X3:  onehot_o = 4'b1000;
            default: onehot_o = 4'b0000;
         endcase
      end else begin
         onehot_o = 4'b0000;
      end
   end

endmodule

// File: rtl/lab02_key_sender.sv
// Replays a captured key code onto the lock keypad lines, then checks whether
// the lock opened within a bounded window.
module lab02_key_sender
   import lab02_pkg::*;
#(
   parameter int CODE_LEN = 4,
   parameter int HOLD_CYC = 1,
   parameter int GAP_CYC  = 1,
   parameter int CHK_CYC  = 4
)(
   input  logic                    clk,
   input  logic                    clean,
   input  logic                    start,
   input  logic [2*CODE_LEN-1:0]   code,
   input  logic                    lock,
   output logic                    X0,
   output logic                    X1,
   output logic                    X2,
   output logic                    X3,
   output logic                    busy,
   output logic                    done,
   output logic                    pass
);

   localparam int DIG_W   = (CODE_LEN < 2) ? 1 : $clog2(CODE_LEN);
   localparam int MAX_CYC = max3(HOLD_CYC, GAP_CYC, CHK_CYC);
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
   localparam logic [CNT_W-1:0] CHK_LD   = CNT_W'(CHK_CYC - 1);
   localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(CODE_LEN - 1);

   state_e                state_q;
   logic [DIG_W-1:0]      digit_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [2*CODE_LEN-1:0] code_q;
   logic [3:0]            x_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  pass_q;

   logic                  last_dig_s;
   logic                  cnt_zero_s;
   logic [DIG_W-1:0]      next_dig_s;
   logic [DIG_W-1:0]      key_dig_s;
   logic                  key_en_s;
   logic [2*CODE_LEN-1:0] sel_code_s;
   logic [1:0]            key_idx_s;
   logic [3:0]            onehot_s;

   assign last_dig_s = (digit_q == LAST_DIG);
   assign cnt_zero_s = (cnt_q == {CNT_W{1'b0}});
   assign next_dig_s = digit_q + DIG_W'(1);

   // Look ahead: which digit, if any, is on the keypad lines next cycle.
   // In IDLE the live code is used since code_q is loaded on the same edge.
   always_comb begin
      key_en_s   = 1'b0;
      key_dig_s  = digit_q;
      sel_code_s = code_q;
      case (state_q)
         ST_IDLE: begin
            sel_code_s = code;
            if (start) begin
               key_en_s  = 1'b1;
               key_dig_s = {DIG_W{1'b0}};
            end else begin
               key_en_s  = 1'b0;
            end
         end
         ST_KEY: begin
            if (!cnt_zero_s) begin
               key_en_s  = 1'b1;
            end else if ((GAP_CYC == 0) && !last_dig_s) begin
               key_en_s  = 1'b1;
               key_dig_s = next_dig_s;
            end else begin
               key_en_s  = 1'b0;
            end
         end
         ST_GAP: begin
            if (cnt_zero_s && !last_dig_s) begin
               key_en_s  = 1'b1;
               key_dig_s = next_dig_s;
            end else begin
               key_en_s  = 1'b0;
            end
         end
         default: begin
            key_en_s = 1'b0;
         end
      endcase
      key_idx_s = sel_code_s[{key_dig_s, 1'b0} +: 2];
   end

   lab02_key_onehot u_onehot (
      .idx_i    (key_idx_s),
      .en_i     (key_en_s),
      .onehot_o (onehot_s)
   );

   // Attempt FSM with its counters, code capture and registered outputs.
   always_ff @(posedge clk) begin
      if (clean) begin
         state_q <= ST_IDLE;
         digit_q <= {DIG_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         code_q  <= {(2*CODE_LEN){1'b0}};
         x_q     <= 4'b0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         x_q <= onehot_s;
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= ST_KEY;
                  code_q  <= code;
                  digit_q <= {DIG_W{1'b0}};
                  cnt_q   <= HOLD_LD;
                  busy_q  <= 1'b1;
                  pass_q  <= 1'b0;
               end
            end
            ST_KEY: begin
               if (!cnt_zero_s) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else if (GAP_CYC > 0) begin
                  state_q <= ST_GAP;
                  cnt_q   <= GAP_LD;
               end else if (last_dig_s) begin
                  state_q <= ST_CHECK;
                  cnt_q   <= CHK_LD;
               end else begin
                  digit_q <= next_dig_s;
                  cnt_q   <= HOLD_LD;
               end
            end
            ST_GAP: begin
               if (!cnt_zero_s) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else if (last_dig_s) begin
                  state_q <= ST_CHECK;
                  cnt_q   <= CHK_LD;
               end else begin
                  state_q <= ST_KEY;
                  digit_q <= next_dig_s;
                  cnt_q   <= HOLD_LD;
               end
            end
            ST_CHECK: begin
               if (lock || cnt_zero_s) begin
                  state_q <= ST_DONE;
                  cnt_q   <= {CNT_W{1'b0}};
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= lock;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign X0   = x_q[0];
   assign X1   = x_q[1];
   assign X2   = x_q[2];
   assign X3   = x_q[3];
   assign busy = busy_q;
   assign done = done_q;
   assign pass = pass_q;

endmodule

// File: tb/tb_lab02_key_sender.sv
// Directed bench for lab02_key_sender: default timing plus a HOLD=2/GAP=0 instance.
module tb_lab02_key_sender;

   logic       clk = 1'b0;
   logic       clean = 1'b1;
   logic       start = 1'b0;
   logic [7:0] code = 8'h00;
   logic       lock = 1'b0;
   logic       x0, x1, x2, x3, busy, done, pass;

   logic       b_start = 1'b0;
   logic [7:0] b_code = 8'h00;
   logic       b_lock = 1'b0;
   logic       b_x0, b_x1, b_x2, b_x3, b_busy, b_done, b_pass;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lab02_key_sender dut (
      .clk(clk), .clean(clean), .start(start), .code(code), .lock(lock),
      .X0(x0), .X1(x1), .X2(x2), .X3(x3), .busy(busy), .done(done), .pass(pass)
   );

   lab02_key_sender #(.CODE_LEN(4), .HOLD_CYC(2), .GAP_CYC(0), .CHK_CYC(4)) dut_b2b (
      .clk(clk), .clean(clean), .start(b_start), .code(b_code), .lock(b_lock),
      .X0(b_x0), .X1(b_x1), .X2(b_x2), .X3(b_x3), .busy(b_busy), .done(b_done), .pass(b_pass)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hand-derived key lines {X3,X2,X1,X0} for code 8'hC2 (digits 2,0,0,3), HOLD=1, GAP=1.
   function automatic logic [3:0] exp_nom_x(input int c);
      case (c)
         1:       return 4'b0100;
         3:       return 4'b0001;
         5:       return 4'b0001;
         7:       return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic test_reset();
      clean = 1'b1;
      step();
      step();
      checks++;
      if ({x3, x2, x1, x0, busy, done, pass} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0000000", {x3, x2, x1, x0, busy, done, pass});
      end
      checks++;
      if ({b_x3, b_x2, b_x1, b_x0, b_busy, b_done, b_pass} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs_b2b: got %b expected 0000000",
                  {b_x3, b_x2, b_x1, b_x0, b_busy, b_done, b_pass});
      end
      clean = 1'b0;
      step();
   endtask

   task automatic test_nominal();
      code  = 8'hC2;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         if (c == 9) lock = 1'b1;
         checks++;
         if ({x3, x2, x1, x0} !== exp_nom_x(c)) begin
            errors++;
            $display("FAIL nominal_x cycle %0d: got %b expected %b", c, {x3, x2, x1, x0}, exp_nom_x(c));
         end
         checks++;
         if (done !== (c == 10)) begin
            errors++;
            $display("FAIL nominal_done cycle %0d: got %b expected %b", c, done, (c == 10));
         end
         checks++;
         if (busy !== (c <= 9)) begin
            errors++;
            $display("FAIL nominal_busy cycle %0d: got %b expected %b", c, busy, (c <= 9));
         end
         if (c >= 10) begin
            checks++;
            if (pass !== 1'b1) begin
               errors++;
               $display("FAIL nominal_pass cycle %0d: got %b expected 1", c, pass);
            end
         end
         step();
      end
      lock = 1'b0;
      step();
   endtask

   task automatic test_ignored_inputs();
      int n_done;
      n_done = 0;
      code   = 8'hC2;
      start  = 1'b1;
      step();
      start  = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         if (c == 3) begin
            start = 1'b1;
            code  = 8'h00;
            lock  = 1'b1;
         end else begin
            start = 1'b0;
            lock  = 1'b0;
         end
         if (c == 1) begin
            checks++;
            if (pass !== 1'b0) begin
               errors++;
               $display("FAIL ignored_pass_cleared: got %b expected 0", pass);
            end
         end
         checks++;
         if ({x3, x2, x1, x0} !== exp_nom_x(c)) begin
            errors++;
            $display("FAIL ignored_x cycle %0d: got %b expected %b", c, {x3, x2, x1, x0}, exp_nom_x(c));
         end
         if (done === 1'b1) n_done++;
         if (c == 13) begin
            checks++;
            if ({done, pass, busy} !== 3'b100) begin
               errors++;
               $display("FAIL ignored_result: got done,pass,busy=%b expected 100", {done, pass, busy});
            end
         end
         step();
      end
      checks++;
      if (n_done != 1) begin
         errors++;
         $display("FAIL ignored_done_count: got %0d expected 1", n_done);
      end
   endtask

   task automatic test_lock_never_opens();
      code  = 8'hC2;
      lock  = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         checks++;
         if ({x3, x2, x1, x0} !== exp_nom_x(c)) begin
            errors++;
            $display("FAIL never_x cycle %0d: got %b expected %b", c, {x3, x2, x1, x0}, exp_nom_x(c));
         end
         checks++;
         if (done !== (c == 13)) begin
            errors++;
            $display("FAIL never_done cycle %0d: got %b expected %b", c, done, (c == 13));
         end
         checks++;
         if (busy !== (c <= 12)) begin
            errors++;
            $display("FAIL never_busy cycle %0d: got %b expected %b", c, busy, (c <= 12));
         end
         if (c == 13) begin
            checks++;
            if (pass !== 1'b0) begin
               errors++;
               $display("FAIL never_pass: got %b expected 0", pass);
            end
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ex;
      b_code  = 8'h1B;
      b_lock  = 1'b0;
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         case (c)
            1, 2:    ex = 4'b1000;
            3, 4:    ex = 4'b0100;
            5, 6:    ex = 4'b0010;
            7, 8:    ex = 4'b0001;
            default: ex = 4'b0000;
         endcase
         checks++;
         if ({b_x3, b_x2, b_x1, b_x0} !== ex) begin
            errors++;
            $display("FAIL b2b_x cycle %0d: got %b expected %b", c, {b_x3, b_x2, b_x1, b_x0}, ex);
         end
         checks++;
         if (b_done !== (c == 13)) begin
            errors++;
            $display("FAIL b2b_done cycle %0d: got %b expected %b", c, b_done, (c == 13));
         end
         checks++;
         if (b_busy !== (c <= 12)) begin
            errors++;
            $display("FAIL b2b_busy cycle %0d: got %b expected %b", c, b_busy, (c <= 12));
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      code  = 8'hC2;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c < 5; c++) step();
      checks++;
      if ({x3, x2, x1, x0} !== 4'b0001) begin
         errors++;
         $display("FAIL rmid_digit2: got %b expected 0001", {x3, x2, x1, x0});
      end
      clean = 1'b1;
      step();
      checks++;
      if ({x3, x2, x1, x0, busy, done, pass} !== 7'b0) begin
         errors++;
         $display("FAIL rmid_cleared: got %b expected 0000000", {x3, x2, x1, x0, busy, done, pass});
      end
      clean = 1'b0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         checks++;
         if ({x3, x2, x1, x0, busy} !== {exp_nom_x(c), 1'b1}) begin
            errors++;
            $display("FAIL rmid_replay cycle %0d: got x,busy=%b expected %b",
                     c, {x3, x2, x1, x0, busy}, {exp_nom_x(c), 1'b1});
         end
         step();
      end
      clean = 1'b1;
      start = 1'b1;
      step();
      checks++;
      if ({x3, x2, x1, x0, busy, done} !== 6'b0) begin
         errors++;
         $display("FAIL rmid_clean_start: got %b expected 000000", {x3, x2, x1, x0, busy, done});
      end
      clean = 1'b0;
      start = 1'b0;
      step();
      checks++;
      if ({x3, x2, x1, x0, busy} !== 5'b0) begin
         errors++;
         $display("FAIL rmid_stays_idle: got %b expected 00000", {x3, x2, x1, x0, busy});
      end
      step();
   endtask

   initial begin
      #1;
      test_reset();
      test_nominal();
      test_ignored_inputs();
      test_lock_never_opens();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
